// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer-pipeline run controller: FSM states,
// mode encodings and the bit positions of the command and finish words.
package layer_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } seq_state_t;

  localparam logic MODE_INFER = 1'b0;
  localparam logic MODE_TRAIN = 1'b1;

  // Command word: {mode, N-1}. Finish word: {error flag, completions-1}.
  // Both carry the count in the low NI bits and the flag in bit NI.
  localparam int CMD_COUNT_LSB = 0;
  localparam int FIN_COUNT_LSB = 0;

  function automatic int cmd_mode_bit(input int ni);
    return ni;
  endfunction

  function automatic int fin_err_bit(input int ni);
    return ni;
  endfunction

endpackage

// File: rtl/layer_sequencer_credit_counter.sv
// Outstanding-sample counter: up on issue, down on completion, unchanged
// when both happen together. Also reports whether the next-cycle count is
// still below the in-flight limit so the issuer can register its valid.
module credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          below_next
);

  logic [CW-1:0] count_next;

  // Next count and look-ahead limit compare.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    if (clr)
      count_next = '0;
    else if (inc && !dec)
      count_next = count + CW'(1);
    else if (dec && !inc)
      count_next = count - CW'(1);
    below_next = (count_next < limit);
  end

  // Count register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else
      count <= count_next;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Run controller for the layer pipeline. Accepts {mode, N-1}, drives the
// shared mode line, issues sample indices with bounded in-flight count,
// counts completion tokens and reports {error, completions-1} on finish.
// Optional: define SEQ_CYCLE_COUNT_EN to add the oCycles run-length counter.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NI    = 10,
  parameter int DEPTH = 4
`ifdef SEQ_CYCLE_COUNT_EN
  , parameter int WC  = 32
`endif
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iValid_AM_Cmd,
  output logic          oReady_AM_Cmd,
  input  logic [NI:0]   iData_AM_Cmd,
  output logic          oMode,
  output logic          oValid_BM_Index,
  input  logic          iReady_BM_Index,
  output logic [NI-1:0] oData_BM_Index,
  input  logic          iValid_AS_Done,
  output logic          oReady_AS_Done,
  output logic          oValid_BM_Fin,
  input  logic          iReady_BM_Fin,
  output logic [NI:0]   oData_BM_Fin,
  output logic          oBusy
`ifdef SEQ_CYCLE_COUNT_EN
  , output logic [WC-1:0] oCycles
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  seq_state_t    state, state_next;
  logic          mode_q;
  logic [NI-1:0] last_q;
  logic [NI-1:0] idx_q;
  logic [NI-1:0] done_cnt_q;
  logic          err_q;
  logic          index_valid_q, index_valid_next;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] limit_next;
  logic          below_next;
  logic          mode_next;
  logic          cmd_hs, index_hs, done_hs, done_ok, done_spur;

  assign oReady_AM_Cmd  = (state == S_IDLE) && !iRST;
  assign oReady_AS_Done = (state == S_RUN) || (state == S_DRAIN);
  assign oValid_BM_Fin  = (state == S_FIN);
  assign oValid_BM_Index = index_valid_q;
  assign oData_BM_Index = idx_q;
  assign oMode          = mode_q;
  assign oBusy          = (state != S_IDLE);

  assign cmd_hs    = iValid_AM_Cmd && oReady_AM_Cmd;
  assign index_hs  = index_valid_q && iReady_BM_Index;
  assign done_hs   = iValid_AS_Done && oReady_AS_Done;
  // A token with nothing in flight is consumed but only flags the error.
  assign done_ok   = done_hs && (outstanding != '0);
  assign done_spur = done_hs && (outstanding == '0);

  // Limit follows the mode that will be in force next cycle, so the first
  // index after command accept already respects the training limit of 1.
  assign mode_next  = cmd_hs ? iData_AM_Cmd[cmd_mode_bit(NI)] : mode_q;
  assign limit_next = (mode_next == MODE_TRAIN) ? CW'(1) : CW'(DEPTH);

  // Finish word is forced to zero outside FIN so reset/idle outputs read 0.
  assign oData_BM_Fin = (state == S_FIN) ? {err_q, done_cnt_q - NI'(1)} : '0;

  credit_counter #(.DEPTH(DEPTH), .CW(CW)) u_credit (
    .clk        (iCLK),
    .rst        (iRST),
    .clr        (cmd_hs),
    .inc        (index_hs),
    .dec        (done_ok),
    .limit      (limit_next),
    .count      (outstanding),
    .below_next (below_next)
  );

  // Next-state decode and registered index-valid look-ahead.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (cmd_hs) state_next = S_RUN;
      S_RUN:   if (index_hs && (idx_q == last_q)) state_next = S_DRAIN;
      S_DRAIN: if (outstanding == '0) state_next = S_FIN;
      S_FIN:   if (iReady_BM_Fin) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    index_valid_next = (state_next == S_RUN) && below_next;
  end

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (iRST)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Run registers: mode, last index, issue/completion counters, error flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mode_q        <= MODE_INFER;
      last_q        <= '0;
      idx_q         <= '0;
      done_cnt_q    <= '0;
      err_q         <= 1'b0;
      index_valid_q <= 1'b0;
    end else begin
      index_valid_q <= index_valid_next;
      if (cmd_hs) begin
        mode_q     <= iData_AM_Cmd[cmd_mode_bit(NI)];
        last_q     <= iData_AM_Cmd[CMD_COUNT_LSB +: NI];
        idx_q      <= '0;
        done_cnt_q <= '0;
        err_q      <= 1'b0;
      end else begin
        if (index_hs)  idx_q      <= idx_q + NI'(1);
        if (done_ok)   done_cnt_q <= done_cnt_q + NI'(1);
        if (done_spur) err_q      <= 1'b1;
      end
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [WC-1:0] cycles_q;

  // Saturating run-length counter, active only while the run is in flight.
  always_ff @(posedge iCLK) begin
    if (iRST)
      cycles_q <= '0;
    else if (cmd_hs)
      cycles_q <= '0;
    else if (((state == S_RUN) || (state == S_DRAIN)) && (cycles_q != '1))
      cycles_q <= cycles_q + WC'(1);
  end

  assign oCycles = cycles_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer. Inputs are driven and outputs sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_layer_sequencer;

  localparam int NI    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          iRST;
  logic          iValid_AM_Cmd;
  logic          oReady_AM_Cmd;
  logic [NI:0]   iData_AM_Cmd;
  logic          oMode;
  logic          oValid_BM_Index;
  logic          iReady_BM_Index;
  logic [NI-1:0] oData_BM_Index;
  logic          iValid_AS_Done;
  logic          oReady_AS_Done;
  logic          oValid_BM_Fin;
  logic          iReady_BM_Fin;
  logic [NI:0]   oData_BM_Fin;
  logic          oBusy;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0]   cycles;
`endif

  int checks = 0;
  int errors = 0;
  int tb_out;     // samples in flight as seen from the bench
  int next_idx;   // next index the bench expects to be issued

  always #5 clk = ~clk;

  layer_sequencer #(.NI(NI), .DEPTH(DEPTH)) dut (
`ifdef SEQ_CYCLE_COUNT_EN
    .oCycles         (cycles),
`endif
    .iCLK            (clk),
    .iRST            (iRST),
    .iValid_AM_Cmd   (iValid_AM_Cmd),
    .oReady_AM_Cmd   (oReady_AM_Cmd),
    .iData_AM_Cmd    (iData_AM_Cmd),
    .oMode           (oMode),
    .oValid_BM_Index (oValid_BM_Index),
    .iReady_BM_Index (iReady_BM_Index),
    .oData_BM_Index  (oData_BM_Index),
    .iValid_AS_Done  (iValid_AS_Done),
    .oReady_AS_Done  (oReady_AS_Done),
    .oValid_BM_Fin   (oValid_BM_Fin),
    .iReady_BM_Fin   (iReady_BM_Fin),
    .oData_BM_Fin    (oData_BM_Fin),
    .oBusy           (oBusy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue one command; returns on the first cycle after acceptance.
  task automatic send_cmd(input logic mode, input int n);
    int w;
    iValid_AM_Cmd = 1'b1;
    iData_AM_Cmd  = {mode, NI'(n - 1)};
    w = 0;
    while (!oReady_AM_Cmd && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (oReady_AM_Cmd !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_timeout: ready=%b required 1", oReady_AM_Cmd);
    end
    tick();
    iValid_AM_Cmd = 1'b0;
    tb_out   = 0;
    next_idx = 0;
    checks++;
    if (oBusy !== 1'b1 || oMode !== mode || oValid_BM_Index !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: busy=%b mode=%b valid=%b required 1 %b 1",
               oBusy, oMode, oValid_BM_Index, mode);
    end
  endtask

  // Service the run until finish, then check and acknowledge the finish word.
  task automatic run_to_fin(input int n, input logic err, input bit rnd, output int cyc);
    bit            hold;
    logic [NI-1:0] held;
    logic [NI:0]   fin_exp;
    hold    = 1'b0;
    held    = '0;
    fin_exp = {err, NI'(n - 1)};
    cyc     = 0;
    while (!oValid_BM_Fin && cyc < 3000) begin
      if (hold) begin
        checks++;
        if (oValid_BM_Index !== 1'b1 || oData_BM_Index !== held) begin
          errors++;
          $display("FAIL index_hold: valid=%b data=%0d required valid=1 data=%0d",
                   oValid_BM_Index, oData_BM_Index, held);
        end
      end
      iReady_BM_Index = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      iValid_AS_Done  = (tb_out > 0) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (iValid_AS_Done && oReady_AS_Done) tb_out--;
      hold = oValid_BM_Index && !iReady_BM_Index;
      held = oData_BM_Index;
      if (oValid_BM_Index && iReady_BM_Index) begin
        checks++;
        if (oData_BM_Index !== NI'(next_idx)) begin
          errors++;
          $display("FAIL index_seq: got %0d required %0d", oData_BM_Index, next_idx);
        end
        next_idx++;
        tb_out++;
      end
      tick();
      cyc++;
    end
    iReady_BM_Index = 1'b0;
    iValid_AS_Done  = 1'b0;
    checks++;
    if (oValid_BM_Fin !== 1'b1) begin
      errors++;
      $display("FAIL fin_timeout: fin valid=%b required 1", oValid_BM_Fin);
    end
    checks++;
    if (next_idx != n) begin
      errors++;
      $display("FAIL index_count: issued %0d required %0d", next_idx, n);
    end
    checks++;
    if (oData_BM_Fin !== fin_exp) begin
      errors++;
      $display("FAIL fin_data: got %h required %h", oData_BM_Fin, fin_exp);
    end
    tick();
    checks++;
    if (oValid_BM_Fin !== 1'b1 || oData_BM_Fin !== fin_exp) begin
      errors++;
      $display("FAIL fin_hold: valid=%b data=%h required 1 %h",
               oValid_BM_Fin, oData_BM_Fin, fin_exp);
    end
    iReady_BM_Fin = 1'b1;
    tick();
    iReady_BM_Fin = 1'b0;
    checks++;
    if (oBusy !== 1'b0 || oReady_AM_Cmd !== 1'b1 || oValid_BM_Fin !== 1'b0) begin
      errors++;
      $display("FAIL fin_to_idle: busy=%b cmd_ready=%b fin=%b required 0 1 0",
               oBusy, oReady_AM_Cmd, oValid_BM_Fin);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (2) tick();
    checks++;
    if (oReady_AM_Cmd !== 1'b0 || oBusy !== 1'b0 || oMode !== 1'b0 ||
        oValid_BM_Index !== 1'b0 || oValid_BM_Fin !== 1'b0 ||
        oData_BM_Fin !== '0 || oData_BM_Index !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b busy=%b mode=%b iv=%b fv=%b fd=%h id=%h required all 0",
               oReady_AM_Cmd, oBusy, oMode, oValid_BM_Index, oValid_BM_Fin,
               oData_BM_Fin, oData_BM_Index);
    end
    iRST = 1'b0;
    tick();
    checks++;
    if (oReady_AM_Cmd !== 1'b1 || oBusy !== 1'b0 || oReady_AS_Done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: cmd_ready=%b busy=%b done_ready=%b required 1 0 0",
               oReady_AM_Cmd, oBusy, oReady_AS_Done);
    end
`ifdef SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_cycles: got %0d required 0", cycles);
    end
`endif
  endtask

  // Inference N=8 with no completions: exactly four indices 0..3, then one
  // completion releases index 4.
  task automatic test_infer_limit();
    int cyc;
    send_cmd(1'b0, 8);
    for (int i = 0; i < 10; i++) begin
      iReady_BM_Index = 1'b1;
      iValid_AS_Done  = 1'b0;
      if (oValid_BM_Index) begin
        checks++;
        if (oData_BM_Index !== NI'(next_idx)) begin
          errors++;
          $display("FAIL limit_seq: got %0d required %0d", oData_BM_Index, next_idx);
        end
        next_idx++;
        tb_out++;
      end
      tick();
    end
    checks++;
    if (next_idx != DEPTH || oValid_BM_Index !== 1'b0) begin
      errors++;
      $display("FAIL limit_stall: issued %0d valid=%b required %0d 0",
               next_idx, oValid_BM_Index, DEPTH);
    end
    iReady_BM_Index = 1'b0;
    iValid_AS_Done  = 1'b1;
    if (oReady_AS_Done) tb_out--;
    tick();
    iValid_AS_Done = 1'b0;
    checks++;
    if (oValid_BM_Index !== 1'b1 || oData_BM_Index !== NI'(4) || oMode !== 1'b0) begin
      errors++;
      $display("FAIL limit_release: valid=%b data=%0d mode=%b required 1 4 0",
               oValid_BM_Index, oData_BM_Index, oMode);
    end
    run_to_fin(8, 1'b0, 1'b0, cyc);
  endtask

  // Training N=3: each index only after the previous completion returns.
  task automatic test_training();
    int cyc;
    int wait_c;
    wait_c = 0;
    send_cmd(1'b1, 3);
    for (int i = 0; i < 200 && !oValid_BM_Fin; i++) begin
      iReady_BM_Index = 1'b1;
      iValid_AS_Done  = (tb_out > 0) && (wait_c == 0);
      if (iValid_AS_Done && oReady_AS_Done) tb_out--;
      if (oValid_BM_Index) begin
        checks++;
        if (tb_out != 0 || oData_BM_Index !== NI'(next_idx) || oMode !== 1'b1) begin
          errors++;
          $display("FAIL train_issue: outstanding=%0d data=%0d mode=%b required 0 %0d 1",
                   tb_out, oData_BM_Index, oMode, next_idx);
        end
        next_idx++;
        tb_out++;
        wait_c = 5;
      end else if (wait_c > 0) begin
        wait_c--;
      end
      tick();
    end
    checks++;
    if (oMode !== 1'b1) begin
      errors++;
      $display("FAIL train_mode: got %b required 1", oMode);
    end
    run_to_fin(3, 1'b0, 1'b0, cyc);
  endtask

  // Inference N=16 with issue and completion in the same cycle throughout.
  task automatic test_back_to_back();
    int cyc;
    send_cmd(1'b0, 16);
    run_to_fin(16, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL b2b_latency: fin after %0d cycles required 18", cyc);
    end
  endtask

  // Completion token arriving with nothing in flight sets the sticky error.
  task automatic test_spurious();
    int cyc;
    send_cmd(1'b0, 4);
    iReady_BM_Index = 1'b0;
    iValid_AS_Done  = 1'b1;
    tick();
    iValid_AS_Done  = 1'b0;
    run_to_fin(4, 1'b1, 1'b0, cyc);
  endtask

  task automatic test_random_ready();
    int cyc;
    send_cmd(1'b0, 12);
    run_to_fin(12, 1'b0, 1'b1, cyc);
  endtask

  task automatic test_reset_midrun();
    int cyc;
    send_cmd(1'b1, 5);
    iReady_BM_Index = 1'b1;
    repeat (2) tick();
    iRST = 1'b1;
    iReady_BM_Index = 1'b0;
    tick();
    checks++;
    if (oBusy !== 1'b0 || oMode !== 1'b0 || oValid_BM_Index !== 1'b0 ||
        oValid_BM_Fin !== 1'b0 || oReady_AM_Cmd !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b mode=%b iv=%b fv=%b rdy=%b required all 0",
               oBusy, oMode, oValid_BM_Index, oValid_BM_Fin, oReady_AM_Cmd);
    end
    iRST = 1'b0;
    tick();
    checks++;
    if (oReady_AM_Cmd !== 1'b1) begin
      errors++;
      $display("FAIL midrun_ready: got %b required 1", oReady_AM_Cmd);
    end
    send_cmd(1'b0, 2);
`ifdef SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycles !== 32'd0) begin
      errors++;
      $display("FAIL cycles_restart: got %0d required 0", cycles);
    end
`endif
    run_to_fin(2, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL short_run_latency: fin after %0d cycles required 4", cyc);
    end
`ifdef SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycles !== 32'd4) begin
      errors++;
      $display("FAIL cycles_count: got %0d required 4", cycles);
    end
`endif
  endtask

  initial begin
    iRST            = 1'b1;
    iValid_AM_Cmd   = 1'b0;
    iData_AM_Cmd    = '0;
    iReady_BM_Index = 1'b0;
    iValid_AS_Done  = 1'b0;
    iReady_BM_Fin   = 1'b0;
    tb_out          = 0;
    next_idx        = 0;
    test_reset();
    test_infer_limit();
    test_training();
    test_back_to_back();
    test_spurious();
    test_random_ready();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Run controller for the layer pipeline: accepts a run command (mode, sample count), drives the shared mode line for every layer, issues sample indices to the input-state fetcher, and counts completion tokens returning from the network tail. It bounds in-flight samples and reports run completion to the host-side control.

## Interface
- NI, 10, sample index width; max run length 2^NI samples
- DEPTH, 4, max in-flight samples in inference mode (training is fixed at 1)
- WC, 32, cycle counter width (only with macro)

- iCLK  in  1  clock
- iRST  in  1  reset; one clock, synchronous, active-high
- iValid_AM_Cmd  in  1  command valid
- oReady_AM_Cmd  out  1  command ready
- iData_AM_Cmd  in  NI+1  bit NI = mode (1 training); [NI-1:0] = N-1
- oMode  out  1  mode line fanned to all layers
- oValid_BM_Index  out  1  sample index valid
- iReady_BM_Index  in  1  fetcher ready
- oData_BM_Index  out  NI  sample index
- iValid_AS_Done  in  1  completion token: output state (inference) or Delta1 update (training)
- oReady_AS_Done  out  1  completion ready
- oValid_BM_Fin  out  1  run finished
- iReady_BM_Fin  in  1  finish acknowledged
- oData_BM_Fin  out  NI+1  {error flag, completions-1}
- oBusy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: oReady_AM_Cmd=1. On Cmd handshake: latch mode to oMode, total N, idx=0, outstanding=0, done_cnt=0, err=0; go RUN.
- RUN: oValid_BM_Index=1 while outstanding < LIMIT (LIMIT=DEPTH if inference, 1 if training). Index handshake: idx+1, outstanding+1. Handshake on idx=N-1 -> DRAIN.
- DRAIN: no issuing; when outstanding=0 -> FIN.
- FIN: oValid_BM_Fin=1, data held; handshake -> IDLE.
- oReady_AS_Done=1 in RUN and DRAIN, 0 otherwise. Done handshake: outstanding-1, done_cnt+1.
- Same-cycle index and done handshakes: outstanding unchanged, both counters advance.
- Done with outstanding=0: token consumed, counters unchanged, err set (sticky to FIN).
- oMode changes only in IDLE on command accept; constant for whole run.
- outstanding width $clog2(DEPTH+1); done_cnt and idx NI bits, no wrap within a run.

## Timing
- Reset values: oReady_AM_Cmd=0 during reset, 1 first cycle after; all other outputs 0; state IDLE.
- Cmd accept cycle t -> oMode valid t+1, first oValid_BM_Index at t+1.
- oValid_BM_Index registered; once high, held with stable data until handshake (never withdrawn while limit holds since outstanding cannot rise without handshake).
- Training: next index issued cycle after done handshake (one-cycle bubble allowed).
- Last done handshake at t -> DRAIN sees outstanding=0 at t+1 -> oValid_BM_Fin at t+2.
- FIN handshake at t -> IDLE at t+1, oReady_AM_Cmd=1 at t+1.
- Reset mid-run: immediate return to IDLE, counters cleared, oMode=0; downstream flushing is the layers' own reset.

## Configuration
- SEQ_CYCLE_COUNT_EN defined: extra output oCycles [WC-1:0], cleared on command accept, increments each cycle in RUN/DRAIN, saturates at all-ones, held in FIN/IDLE.
- Not defined: port absent, no counter logic.

## Structure
- Shared package: state enum (IDLE/RUN/DRAIN/FIN), mode constants (MODE_INFER=0, MODE_TRAIN=1), Cmd/Fin field offsets.
- One sub-module: credit_counter (up/down outstanding counter with limit compare, simultaneous inc/dec).

## Test plan
- Inference, N=8, DEPTH=4, Done held low: exactly 4 indices 0..3 issued, then oValid_BM_Index stays 0; return 1 done -> index 4 issued.
- Training, N=3, Done returned 5 cycles after each index: indices 0,1,2 each issued only after previous done; oMode=1 throughout; Fin data {0,2}.
- Simultaneous index and done handshakes each cycle, inference N=16: outstanding constant, Fin {0,15}.
- Spurious done in DRAIN after all tokens returned... i.e. extra done with outstanding=0: Fin {1,N-1}.
- iReady_BM_Index toggled randomly: oData_BM_Index stable while valid and not ready; no index skipped or repeated.
- iRST asserted mid-RUN: next cycle oBusy=0, oMode=0, new command N=2 runs cleanly; with SEQ_CYCLE_COUNT_EN, oCycles restarts from 0.
